// File: rtl/riscv_pkg.sv
// Shared RV32 constants used by fetch, decode and the main controller.
package riscv_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for prefetched {pc, instr} entries; clear wins over push and pop.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o & ~clear_i;
    assign do_pop  = pop_i & ~empty_o & ~clear_i;

    always_ff @(posedge clk) begin
        if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order imem requests, prefetch FIFO, Decode register.
module fetch_unit #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);
    import riscv_pkg::*;

    localparam int              CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int              ENT_W      = XLEN + 32;
    localparam logic [CNT_W:0]  DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] RESET_PC_A = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d, kill_cnt_q, kill_cnt_d;
    logic [31:0]      instr_q;
    logic [XLEN-1:0]  pcd_q, pcp4_q;
    logic             valid_q;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full, fifo_clear;
    logic             push, pop, handshake, credit_ok;
    logic [ENT_W-1:0] head;
    logic             unused_tgt_lsb;

    assign target         = {PCTargetE[XLEN-1:2], 2'b00};
    assign unused_tgt_lsb = ^PCTargetE[1:0];

    // Credits cover in-flight requests plus buffered entries, so every response has a free slot.
    assign pop       = ~PCSrcE & ~FlushD & ~StallD & ~fifo_empty;
    assign credit_ok = ({1'b0, out_cnt_q} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop}) < DEPTH_C;

    assign imem_req_valid = reset & ~PCSrcE & credit_ok;
    assign imem_addr      = pc_q;
    assign handshake      = imem_req_valid & imem_req_ready;
    assign push           = imem_rsp_valid & ~PCSrcE & (kill_cnt_q == '0) & ~fifo_full;
    assign fifo_clear     = ~reset | PCSrcE;

    fetch_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .clear_i     (fifo_clear),
        .push_i      (push),
        .push_data_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // rsp_pc tracks the PC of the next accepted response; requests after a redirect are sequential.
    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        kill_cnt_d = kill_cnt_q;
        out_cnt_d  = out_cnt_q + CNT_W'(handshake) - CNT_W'(imem_rsp_valid);
        if (PCSrcE) begin
            pc_d       = target;
            rsp_pc_d   = target;
            kill_cnt_d = out_cnt_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (handshake) pc_d = pc_q + XLEN'(4);
            if (push) rsp_pc_d = rsp_pc_q + XLEN'(4);
            if (imem_rsp_valid && kill_cnt_q != '0) kill_cnt_d = kill_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC_A;
            rsp_pc_q   <= RESET_PC_A;
            out_cnt_q  <= '0;
            kill_cnt_q <= '0;
            instr_q    <= NOP_INSTR;
            pcd_q      <= '0;
            pcp4_q     <= XLEN'(4);
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_cnt_q  <= out_cnt_d;
            kill_cnt_q <= kill_cnt_d;
            if (PCSrcE || FlushD) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end else if (StallD) begin
                valid_q <= valid_q;
            end else if (!fifo_empty) begin
                instr_q <= head[31:0];
                pcd_q   <= head[ENT_W-1:32];
                pcp4_q  <= head[ENT_W-1:32] + XLEN'(4);
                valid_q <= 1'b1;
            end else begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory model and a PC scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE, InstrD, PCD, PCPlus4D;
    logic        ValidD;

    logic        req_valid1, rsp_valid1, valid1;
    logic [31:0] addr1, rsp_data1, instr1, pcd1, pcp41;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid1), .imem_req_ready(1'b1), .imem_addr(addr1),
        .imem_rsp_valid(rsp_valid1), .imem_rsp_data(rsp_data1),
        .StallD(1'b0), .FlushD(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .InstrD(instr1), .PCD(pcd1), .PCPlus4D(pcp41), .ValidD(valid1)
    );

    int          n_vec = 0, n_err = 0;
    int          lat = 1, cyc = 0;
    logic [31:0] sb[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] a1q[$];
    logic [31:0] exp_pc, hs_addr, hs_addr1, target_exp;
    logic        hs, hs1, taken, armed = 1'b0, seen_wrap = 1'b0;
    logic [31:0] last_instr, last_pcd;
    logic        last_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: samples requests mid-cycle, answers in order after lat cycles, data = address.
    initial begin : memory
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        rsp_valid1     = 1'b0;
        rsp_data1      = '0;
        forever begin
            @(negedge clk);
            hs    = 1'b0;
            hs1   = 1'b0;
            taken = imem_rsp_valid;
            if (!reset) begin
                chk("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
                exp_pc = 32'h0;
                sb.delete();
            end else if (PCSrcE) begin
                chk("no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
                sb.delete();
                exp_pc = {PCTargetE[31:2], 2'b00};
            end else if (imem_req_valid && imem_req_ready) begin
                hs      = 1'b1;
                hs_addr = imem_addr;
                chk("fetch_addr", hs_addr, exp_pc);
                sb.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (reset && req_valid1) begin
                hs1      = 1'b1;
                hs_addr1 = addr1;
                if (a1q.size() < 3) a1q.push_back(hs_addr1);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (taken && pend_addr.size() > 0) begin
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (hs) begin
                    pend_addr.push_back(hs_addr);
                    pend_due.push_back(cyc + lat - 1);
                    chk("outstanding_le_depth", {31'b0, pend_addr.size() <= 2}, 32'd1);
                end
            end
            imem_rsp_valid = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
            imem_rsp_data  = imem_rsp_valid ? pend_addr[0] : 32'h0;
            rsp_valid1     = hs1;
            rsp_data1      = hs_addr1;
        end
    end

    task automatic check_decode();
        logic [31:0] e;
        if (!reset) begin
            chk("rst_instr", InstrD, NOP);
            chk("rst_pcd", PCD, 32'h0);
            chk("rst_pcplus4", PCPlus4D, 32'h4);
            chk("rst_valid", {31'b0, ValidD}, 32'd0);
        end else if (PCSrcE || FlushD) begin
            chk("bubble_valid", {31'b0, ValidD}, 32'd0);
            chk("bubble_instr", InstrD, NOP);
        end else if (StallD) begin
            chk("stall_instr", InstrD, last_instr);
            chk("stall_pcd", PCD, last_pcd);
            chk("stall_valid", {31'b0, ValidD}, {31'b0, last_valid});
        end else if (ValidD) begin
            chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dec_pcd", PCD, e);
                chk("dec_instr", InstrD, e);
                chk("dec_pcplus4", PCPlus4D, e + 32'd4);
                if (armed) begin
                    chk("redirect_pcd", PCD, target_exp);
                    chk("redirect_pcplus4", PCPlus4D, target_exp + 32'd4);
                    armed = 1'b0;
                end
            end
        end else begin
            chk("idle_instr", InstrD, NOP);
        end
        if (reset && valid1 && pcd1 == 32'hFFFF_FFFC) begin
            chk("wrap_instr", instr1, 32'hFFFF_FFFC);
            chk("wrap_pcplus4", pcp41, 32'h0);
            seen_wrap = 1'b1;
        end
        last_instr = InstrD;
        last_pcd   = PCD;
        last_valid = ValidD;
    endtask

    task automatic step();
        @(posedge clk);
        #3;
        check_decode();
    endtask

    initial begin
        int k;
        reset = 1'b0; imem_req_ready = 1'b1;
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;

        // Reset then free-run with a 1-cycle memory.
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        chk("first_valid", {31'b0, ValidD}, 32'd1);
        chk("first_pcd", PCD, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("stream_valid", {31'b0, ValidD}, 32'd1);
        end

        // Stall mid-stream.
        StallD = 1'b1;
        repeat (4) step();
        StallD = 1'b0;
        repeat (8) step();

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        repeat (6) step();
        k = 0;
        while (pend_addr.size() != 2 && k < 20) begin
            step();
            k++;
        end
        chk("two_in_flight", 32'(pend_addr.size()), 32'd2);
        PCSrcE = 1'b1; PCTargetE = 32'h100; target_exp = 32'h100; armed = 1'b1;
        step();
        PCSrcE = 1'b0;
        repeat (15) step();
        chk("redirect_delivered", {31'b0, armed}, 32'd0);

        // Redirect together with stall; target low bits are ignored.
        lat = 1;
        StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h202; target_exp = 32'h200; armed = 1'b1;
        step();
        chk("rs_valid", {31'b0, ValidD}, 32'd0);
        chk("rs_instr", InstrD, NOP);
        StallD = 1'b0; PCSrcE = 1'b0;
        repeat (12) step();
        chk("rs_delivered", {31'b0, armed}, 32'd0);

        // Backpressure plus a single FlushD pulse.
        for (int i = 0; i < 16; i++) begin
            imem_req_ready = i[0];
            FlushD = (i == 9);
            step();
        end
        imem_req_ready = 1'b1; FlushD = 1'b0;
        repeat (10) step();

        // Wrap-around instance.
        chk("wrap_addr_count", 32'(a1q.size()), 32'd3);
        if (a1q.size() >= 3) begin
            chk("wrap_addr0", a1q[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", a1q[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", a1q[2], 32'h0000_0000);
        end
        chk("wrap_seen", {31'b0, seen_wrap}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
